pio_ep_reg_bank: RTL and testbench
==================================

PIO_EP_REG_BANK -- requirements
Module: pio_ep_reg_bank

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of network channels (legal range 1..8).
REQ-002 The module SHALL have parameter TCQ, default 1, giving the simulation clock-to-out delay in ps.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port sys_rst, input, width 1: reset, synchronous and active-high.
REQ-005 The module SHALL have port rd_addr, input, width 14: DWORD read address.
REQ-006 The module SHALL have port rd_en, input, width 1: read request.
REQ-007 The module SHALL have port rd_data, output, width 32: read data.
REQ-008 The module SHALL have port rd_valid, output, width 1: rd_data is valid this cycle.
REQ-009 The module SHALL have port wr_addr, input, width 14: DWORD write address.
REQ-010 The module SHALL have port wr_be, input, width 8: byte enables; only [3:0] are used, and wr_be[0] selects wr_data[31:24] through wr_be[3] selecting wr_data[7:0].
REQ-011 The module SHALL have port wr_data, input, width 32: write data.
REQ-012 The module SHALL have port wr_en, input, width 1: write request.
REQ-013 The module SHALL have port wr_busy, output, width 1: writes are refused this cycle.
REQ-014 The module SHALL have port bios_data, input, width 32: ROM data, valid one cycle after rd_addr.
REQ-015 The module SHALL have ports if_v4addr, if_macaddr, dest_v4addr and dest_macaddr, outputs, widths 32*NUM_CH, 48*NUM_CH, 32*NUM_CH and 48*NUM_CH: live per-channel values, channel n in slice n.

Function
REQ-016 The module SHALL decode rd_addr[13:12] and wr_addr[13:12] as follows: 00 reserved (reads 0), 01 register bank, 10 reserved (reads 0), 11 BIOS (reads bios_data; writes ignored).
REQ-017 In the bank region, the module SHALL use address bits [5:3] as the channel and bits [2:0] as the offset; an access with channel >= NUM_CH SHALL read 0 and ignore writes.
REQ-018 The module SHALL map offsets as: 0 if_v4addr; 1 control/status; 2 if_mac[47:16]; 3 {if_mac[15:0],16'h0}; 4 dest_v4addr; 5 commit_count (8-bit, zero-extended); 6 dest_mac[47:16]; 7 {dest_mac[15:0],16'h0}.
REQ-019 Data-register writes at offsets 0, 2, 3, 4, 6 and 7 SHALL update only the channel's shadow copy, per byte lane; at offsets 3 and 7 only lanes 0 and 1 are writable.
REQ-020 Data-register reads SHALL return the shadow copy.
REQ-021 Reads at offset 1 SHALL return {pending, 31'b0}, where pending is set by any shadow write to the channel and cleared by that channel's commit.
REQ-022 A write at offset 1 with wr_be[0]=1 and wr_data[24]=1 SHALL be a commit; on the next cycle the channel's live outputs SHALL take the shadow values, commit_count SHALL increment (255 wraps to 0), and pending SHALL clear.
REQ-023 wr_busy SHALL be 1 for exactly the cycle after an accepted commit and 0 otherwise.
REQ-024 A write is accepted only when wr_en=1 and wr_busy=0; a wr_en asserted while wr_busy=1 SHALL be dropped without effect.
REQ-025 A read with rd_en=1 in cycle N SHALL produce rd_valid=1 and rd_data in cycle N+1, for all regions; when rd_valid=0, rd_data SHALL be 0.
REQ-026 When a read and a write target the same word in the same cycle, the read SHALL return the pre-write value.
REQ-027 Live outputs SHALL change only at reset or on a commit, never on a shadow write.

Reset
REQ-028 On sys_rst, both the shadow and live copies of channel n SHALL reset to: if_v4addr = 10.0.21.(199+n); if_macaddr = 48'h003776_000001 + n; dest_v4addr = 10.0.21.255; dest_macaddr = 48'hffffff_ffffff.
REQ-029 On sys_rst, pending, commit_count, rd_valid, rd_data and wr_busy SHALL all reset to 0.
REQ-030 Reset asserted in the cycle after a commit SHALL win: the reset values are loaded and the commit is discarded.

Structure
REQ-031 The offset constants, region codes and per-channel default values SHALL be defined in the shared package pio_ep_pkg.
REQ-032 One sub-module, pio_ep_reg_ch, SHALL hold the shadow copy, live copy, pending flag and counter for a single channel, instantiated NUM_CH times; the read mux and commit sequencing SHALL be in the top level.

Verification
REQ-033 Reset, then read ch1 offset 0 -> rd_valid after 1 cycle, rd_data = 0x0A0015C8.
REQ-034 Write ch2 offset 2 = 0x11223344 with be = 0xF -> live if_macaddr[2] unchanged and offset 1 reads 0x80000000; then commit -> live = 0x11223344_0003, the cycle after the commit has wr_busy = 1, commit_count = 1, and offset 1 reads 0.
REQ-035 Write ch0 offset 4 with wr_be = 0x2 and data 0x00AB0000 -> shadow dest_v4addr = 0x0AAB15FF.
REQ-036 Issue a commit, then a write on the next cycle while busy -> the second write is dropped; issue 256 commits -> commit_count returns to 0.
REQ-037 Read rd_addr 0x3004 -> rd_data = bios_data at 1-cycle latency; with NUM_CH = 4, a write to channel 5 -> no state changes and a read of it returns 0.

Source files
------------

// File: rtl/pio_ep_pkg.sv
// Shared constants for the PIO endpoint register bank: address regions,
// register offsets, per-channel reset values and the byte-lane merge helpers.
package pio_ep_pkg;

    typedef enum logic [1:0] {
        REGION_RSVD0 = 2'b00,
        REGION_BANK  = 2'b01,
        REGION_RSVD2 = 2'b10,
        REGION_BIOS  = 2'b11
    } region_e;

    typedef enum logic [2:0] {
        OFF_IF_V4       = 3'd0,
        OFF_CTRL        = 3'd1,
        OFF_IF_MAC_HI   = 3'd2,
        OFF_IF_MAC_LO   = 3'd3,
        OFF_DEST_V4     = 3'd4,
        OFF_COMMIT_CNT  = 3'd5,
        OFF_DEST_MAC_HI = 3'd6,
        OFF_DEST_MAC_LO = 3'd7
    } offset_e;

    localparam int          MAX_CH           = 8;
    localparam int          COMMIT_BIT       = 24;
    localparam logic [31:0] IF_V4_BASE       = 32'h0A00_15C7;
    localparam logic [47:0] IF_MAC_BASE      = 48'h0037_7600_0001;
    localparam logic [31:0] DEST_V4_DEFAULT  = 32'h0A00_15FF;
    localparam logic [47:0] DEST_MAC_DEFAULT = 48'hFFFF_FFFF_FFFF;

    function automatic logic [31:0] default_if_v4(input int ch);
        return IF_V4_BASE + 32'(ch);
    endfunction

    function automatic logic [47:0] default_if_mac(input int ch);
        return IF_MAC_BASE + 48'(ch);
    endfunction

    // Lane k (enable bit k) covers the byte that starts at bit 31-8k.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[31-8*k -: 8] = new_word[31-8*k -: 8];
        end
        return res;
    endfunction

    // Low-half registers only expose lanes 0 and 1 (bits 31:16 of the word).
    function automatic logic [15:0] merge_upper16(input logic [15:0] old_half,
                                                  input logic [31:0] new_word,
                                                  input logic [1:0]  be);
        logic [15:0] res;
        res = old_half;
        if (be[0]) res[15:8] = new_word[31:24];
        if (be[1]) res[7:0]  = new_word[23:16];
        return res;
    endfunction

endpackage

// File: rtl/pio_ep_reg_ch.sv
// One network channel: shadow and live address copies, the pending flag
// and the 8-bit commit counter.
module pio_ep_reg_ch
    import pio_ep_pkg::*;
#(
    parameter int CH_IDX = 0
)
(
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_off,
    input  logic [3:0]  i_wr_be,
    input  logic [31:0] i_wr_data,
    input  logic        i_commit,
    output logic [31:0] o_sh_if_v4,
    output logic [47:0] o_sh_if_mac,
    output logic [31:0] o_sh_dest_v4,
    output logic [47:0] o_sh_dest_mac,
    output logic [31:0] o_live_if_v4,
    output logic [47:0] o_live_if_mac,
    output logic [31:0] o_live_dest_v4,
    output logic [47:0] o_live_dest_mac,
    output logic        o_pending,
    output logic [7:0]  o_commit_cnt
);

    logic [31:0] r_sh_if_v4;
    logic [47:0] r_sh_if_mac;
    logic [31:0] r_sh_dest_v4;
    logic [47:0] r_sh_dest_mac;
    logic [31:0] r_live_if_v4;
    logic [47:0] r_live_if_mac;
    logic [31:0] r_live_dest_v4;
    logic [47:0] r_live_dest_mac;
    logic        r_pending;
    logic [7:0]  r_commit_cnt;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_sh_if_v4      <= default_if_v4(CH_IDX);
            r_sh_if_mac     <= default_if_mac(CH_IDX);
            r_sh_dest_v4    <= DEST_V4_DEFAULT;
            r_sh_dest_mac   <= DEST_MAC_DEFAULT;
            r_live_if_v4    <= default_if_v4(CH_IDX);
            r_live_if_mac   <= default_if_mac(CH_IDX);
            r_live_dest_v4  <= DEST_V4_DEFAULT;
            r_live_dest_mac <= DEST_MAC_DEFAULT;
            r_pending       <= 1'b0;
            r_commit_cnt    <= 8'd0;
        end else if (i_commit) begin
            r_live_if_v4    <= r_sh_if_v4;
            r_live_if_mac   <= r_sh_if_mac;
            r_live_dest_v4  <= r_sh_dest_v4;
            r_live_dest_mac <= r_sh_dest_mac;
            r_commit_cnt    <= r_commit_cnt + 8'd1;
            r_pending       <= 1'b0;
        end else if (i_wr_en) begin
            r_pending <= 1'b1;
            case (i_wr_off)
                OFF_IF_V4:       r_sh_if_v4 <= merge_lanes(r_sh_if_v4, i_wr_data, i_wr_be);
                OFF_IF_MAC_HI:   r_sh_if_mac[47:16] <= merge_lanes(r_sh_if_mac[47:16], i_wr_data, i_wr_be);
                OFF_IF_MAC_LO:   r_sh_if_mac[15:0] <= merge_upper16(r_sh_if_mac[15:0], i_wr_data, i_wr_be[1:0]);
                OFF_DEST_V4:     r_sh_dest_v4 <= merge_lanes(r_sh_dest_v4, i_wr_data, i_wr_be);
                OFF_DEST_MAC_HI: r_sh_dest_mac[47:16] <= merge_lanes(r_sh_dest_mac[47:16], i_wr_data, i_wr_be);
                OFF_DEST_MAC_LO: r_sh_dest_mac[15:0] <= merge_upper16(r_sh_dest_mac[15:0], i_wr_data, i_wr_be[1:0]);
                default: ;
            endcase
        end
    end

    assign o_sh_if_v4      = r_sh_if_v4;
    assign o_sh_if_mac     = r_sh_if_mac;
    assign o_sh_dest_v4    = r_sh_dest_v4;
    assign o_sh_dest_mac   = r_sh_dest_mac;
    assign o_live_if_v4    = r_live_if_v4;
    assign o_live_if_mac   = r_live_if_mac;
    assign o_live_dest_v4  = r_live_dest_v4;
    assign o_live_dest_mac = r_live_dest_mac;
    assign o_pending       = r_pending;
    assign o_commit_cnt    = r_commit_cnt;

endmodule

// File: rtl/pio_ep_reg_bank.sv
// PIO endpoint register bank: address decode, write acceptance, commit
// sequencing and the registered read mux over channels and BIOS ROM.
module pio_ep_reg_bank
    import pio_ep_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TCQ    = 1
)
(
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic [13:0]           rd_addr,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    input  logic [13:0]           wr_addr,
    input  logic [7:0]            wr_be,
    input  logic [31:0]           wr_data,
    input  logic                  wr_en,
    output logic                  wr_busy,
    input  logic [31:0]           bios_data,
    output logic [32*NUM_CH-1:0]  if_v4addr,
    output logic [48*NUM_CH-1:0]  if_macaddr,
    output logic [32*NUM_CH-1:0]  dest_v4addr,
    output logic [48*NUM_CH-1:0]  dest_macaddr
);

    logic        r_rd_valid;
    logic        r_rd_bios;
    logic [31:0] r_rd_data;
    logic        r_wr_busy;

    logic [2:0]  w_wr_ch;
    logic [2:0]  w_wr_off;
    logic        w_wr_ch_ok;
    logic        w_wr_bank;
    logic        w_commit;
    logic        w_sh_wr;
    logic [2:0]  w_rd_ch;
    logic [31:0] w_rd_word;
    logic        w_unused;

    logic [31:0] w_sh_if_v4    [MAX_CH];
    logic [47:0] w_sh_if_mac   [MAX_CH];
    logic [31:0] w_sh_dest_v4  [MAX_CH];
    logic [47:0] w_sh_dest_mac [MAX_CH];
    logic        w_pending     [MAX_CH];
    logic [7:0]  w_commit_cnt  [MAX_CH];

    assign w_wr_ch    = wr_addr[5:3];
    assign w_wr_off   = wr_addr[2:0];
    assign w_wr_ch_ok = ({1'b0, w_wr_ch} < 4'(NUM_CH));
    assign w_wr_bank  = wr_en && !r_wr_busy && (wr_addr[13:12] == REGION_BANK) && w_wr_ch_ok;
    assign w_commit   = w_wr_bank && (w_wr_off == OFF_CTRL) && wr_be[0] && wr_data[COMMIT_BIT];
    // The counter register is read-only; control writes only matter as commits.
    assign w_sh_wr    = w_wr_bank && (w_wr_off != OFF_CTRL) && (w_wr_off != OFF_COMMIT_CNT);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_CH; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_present
                logic [31:0] w_live_if_v4;
                logic [47:0] w_live_if_mac;
                logic [31:0] w_live_dest_v4;
                logic [47:0] w_live_dest_mac;

                pio_ep_reg_ch #(.CH_IDX(gi)) u_ch (
                    .clk             (clk),
                    .sys_rst         (sys_rst),
                    .i_wr_en         (w_sh_wr && (w_wr_ch == 3'(gi))),
                    .i_wr_off        (w_wr_off),
                    .i_wr_be         (wr_be[3:0]),
                    .i_wr_data       (wr_data),
                    .i_commit        (w_commit && (w_wr_ch == 3'(gi))),
                    .o_sh_if_v4      (w_sh_if_v4[gi]),
                    .o_sh_if_mac     (w_sh_if_mac[gi]),
                    .o_sh_dest_v4    (w_sh_dest_v4[gi]),
                    .o_sh_dest_mac   (w_sh_dest_mac[gi]),
                    .o_live_if_v4    (w_live_if_v4),
                    .o_live_if_mac   (w_live_if_mac),
                    .o_live_dest_v4  (w_live_dest_v4),
                    .o_live_dest_mac (w_live_dest_mac),
                    .o_pending       (w_pending[gi]),
                    .o_commit_cnt    (w_commit_cnt[gi])
                );

                assign if_v4addr[32*gi +: 32]    = w_live_if_v4;
                assign if_macaddr[48*gi +: 48]   = w_live_if_mac;
                assign dest_v4addr[32*gi +: 32]  = w_live_dest_v4;
                assign dest_macaddr[48*gi +: 48] = w_live_dest_mac;
            end else begin : g_absent
                // Unpopulated channel slots read back as zero.
                assign w_sh_if_v4[gi]    = '0;
                assign w_sh_if_mac[gi]   = '0;
                assign w_sh_dest_v4[gi]  = '0;
                assign w_sh_dest_mac[gi] = '0;
                assign w_pending[gi]     = 1'b0;
                assign w_commit_cnt[gi]  = '0;
            end
        end
    endgenerate

    assign w_rd_ch = rd_addr[5:3];

    always_comb begin
        w_rd_word = '0;
        if (rd_addr[13:12] == REGION_BANK) begin
            case (rd_addr[2:0])
                OFF_IF_V4:       w_rd_word = w_sh_if_v4[w_rd_ch];
                OFF_CTRL:        w_rd_word = {w_pending[w_rd_ch], 31'b0};
                OFF_IF_MAC_HI:   w_rd_word = w_sh_if_mac[w_rd_ch][47:16];
                OFF_IF_MAC_LO:   w_rd_word = {w_sh_if_mac[w_rd_ch][15:0], 16'h0};
                OFF_DEST_V4:     w_rd_word = w_sh_dest_v4[w_rd_ch];
                OFF_COMMIT_CNT:  w_rd_word = {24'b0, w_commit_cnt[w_rd_ch]};
                OFF_DEST_MAC_HI: w_rd_word = w_sh_dest_mac[w_rd_ch][47:16];
                OFF_DEST_MAC_LO: w_rd_word = {w_sh_dest_mac[w_rd_ch][15:0], 16'h0};
                default:         w_rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_bios  <= 1'b0;
            r_rd_data  <= '0;
            r_wr_busy  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_bios  <= rd_en && (rd_addr[13:12] == REGION_BIOS);
            r_rd_data  <= rd_en ? w_rd_word : '0;
            r_wr_busy  <= w_commit;
        end
    end

    // The ROM answers one cycle after the address, so its word bypasses the read register.
    assign rd_data  = r_rd_bios ? bios_data : r_rd_data;
    assign rd_valid = r_rd_valid;
    assign wr_busy  = r_wr_busy;

    assign w_unused = ^{wr_be[7:4], rd_addr[11:6], wr_addr[11:6], 1'(TCQ)};

endmodule

// File: tb/tb_pio_ep_reg_bank.sv
// Self-checking bench for pio_ep_reg_bank: a reference model predicts every
// read into a scoreboard queue; a negedge monitor pops and compares.
module tb_pio_ep_reg_bank;

    localparam int NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 sys_rst = 1'b1;
    logic [13:0]          rd_addr = '0;
    logic                 rd_en = 1'b0;
    logic [31:0]          rd_data;
    logic                 rd_valid;
    logic [13:0]          wr_addr = '0;
    logic [7:0]           wr_be = '0;
    logic [31:0]          wr_data = '0;
    logic                 wr_en = 1'b0;
    logic                 wr_busy;
    logic [31:0]          bios_data = '0;
    logic [32*NUM_CH-1:0] if_v4addr;
    logic [48*NUM_CH-1:0] if_macaddr;
    logic [32*NUM_CH-1:0] dest_v4addr;
    logic [48*NUM_CH-1:0] dest_macaddr;

    always #5 clk = ~clk;

    pio_ep_reg_bank #(.NUM_CH(NUM_CH), .TCQ(1)) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_addr      (wr_addr),
        .wr_be        (wr_be),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_busy      (wr_busy),
        .bios_data    (bios_data),
        .if_v4addr    (if_v4addr),
        .if_macaddr   (if_macaddr),
        .dest_v4addr  (dest_v4addr),
        .dest_macaddr (dest_macaddr)
    );

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        return 32'hB105_0000 ^ {a, 4'h0, a};
    endfunction

    always @(posedge clk) bios_data <= rom_word(rd_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model
    logic [31:0] m_sh_if_v4 [NUM_CH];
    logic [47:0] m_sh_if_mac[NUM_CH];
    logic [31:0] m_sh_dv4   [NUM_CH];
    logic [47:0] m_sh_dmac  [NUM_CH];
    logic [31:0] m_lv_if_v4 [NUM_CH];
    logic [47:0] m_lv_if_mac[NUM_CH];
    logic [31:0] m_lv_dv4   [NUM_CH];
    logic [47:0] m_lv_dmac  [NUM_CH];
    logic        m_pend     [NUM_CH];
    logic [7:0]  m_cnt      [NUM_CH];
    logic        m_busy = 1'b0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sb_q[$];

    task automatic model_reset();
        for (int n = 0; n < NUM_CH; n++) begin
            m_sh_if_v4[n]  = {8'd10, 8'd0, 8'd21, 8'(199 + n)};
            m_sh_if_mac[n] = 48'h003776_000001 + 48'(n);
            m_sh_dv4[n]    = {8'd10, 8'd0, 8'd21, 8'd255};
            m_sh_dmac[n]   = {48{1'b1}};
            m_lv_if_v4[n]  = m_sh_if_v4[n];
            m_lv_if_mac[n] = m_sh_if_mac[n];
            m_lv_dv4[n]    = m_sh_dv4[n];
            m_lv_dmac[n]   = m_sh_dmac[n];
            m_pend[n]      = 1'b0;
            m_cnt[n]       = 8'd0;
        end
        m_busy = 1'b0;
    endtask

    function automatic logic [31:0] put_lanes(input logic [31:0] old, input logic [31:0] d, input logic [7:0] be);
        logic [31:0] msk;
        msk = {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
        return (old & ~msk) | (d & msk);
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a);
        int ch;
        ch = int'(a[5:3]);
        if (a[13:12] == 2'b11) return rom_word(a);
        if (a[13:12] != 2'b01 || ch >= NUM_CH) return 32'h0;
        case (a[2:0])
            3'd0: return m_sh_if_v4[ch];
            3'd1: return {m_pend[ch], 31'b0};
            3'd2: return m_sh_if_mac[ch][47:16];
            3'd3: return {m_sh_if_mac[ch][15:0], 16'h0};
            3'd4: return m_sh_dv4[ch];
            3'd5: return {24'b0, m_cnt[ch]};
            3'd6: return m_sh_dmac[ch][47:16];
            default: return {m_sh_dmac[ch][15:0], 16'h0};
        endcase
    endfunction

    task automatic model_write(input logic [13:0] a, input logic [7:0] be, input logic [31:0] d, output logic committed);
        int ch;
        logic [31:0] t;
        committed = 1'b0;
        ch = int'(a[5:3]);
        if (a[13:12] == 2'b01 && ch < NUM_CH) begin
            case (a[2:0])
                3'd0: begin m_sh_if_v4[ch] = put_lanes(m_sh_if_v4[ch], d, be); m_pend[ch] = 1'b1; end
                3'd1: if (be[0] && d[24]) begin
                    m_lv_if_v4[ch]  = m_sh_if_v4[ch];
                    m_lv_if_mac[ch] = m_sh_if_mac[ch];
                    m_lv_dv4[ch]    = m_sh_dv4[ch];
                    m_lv_dmac[ch]   = m_sh_dmac[ch];
                    m_cnt[ch]       = m_cnt[ch] + 8'd1;
                    m_pend[ch]      = 1'b0;
                    committed       = 1'b1;
                end
                3'd2: begin
                    t = put_lanes(m_sh_if_mac[ch][47:16], d, be);
                    m_sh_if_mac[ch][47:16] = t; m_pend[ch] = 1'b1;
                end
                3'd3: begin
                    t = put_lanes({m_sh_if_mac[ch][15:0], 16'h0}, d, be & 8'h03);
                    m_sh_if_mac[ch][15:0] = t[31:16]; m_pend[ch] = 1'b1;
                end
                3'd4: begin m_sh_dv4[ch] = put_lanes(m_sh_dv4[ch], d, be); m_pend[ch] = 1'b1; end
                3'd6: begin
                    t = put_lanes(m_sh_dmac[ch][47:16], d, be);
                    m_sh_dmac[ch][47:16] = t; m_pend[ch] = 1'b1;
                end
                3'd7: begin
                    t = put_lanes({m_sh_dmac[ch][15:0], 16'h0}, d, be & 8'h03);
                    m_sh_dmac[ch][15:0] = t[31:16]; m_pend[ch] = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // One clock cycle of stimulus; the model sees the read before the write.
    task automatic do_cycle(input logic re, input logic [13:0] ra,
                            input logic we, input logic [13:0] wa,
                            input logic [7:0] be, input logic [31:0] wd);
        logic committed;
        @(posedge clk); #1;
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        check_val("wr_busy", 64'(wr_busy), 64'(m_busy));
        if (re) sb_q.push_back('{data: model_read(ra), cyc: cyc});
        committed = 1'b0;
        if (we && !m_busy) model_write(wa, be, wd, committed);
        m_busy = committed;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 14'h0, 1'b0, 14'h0, 8'h0, 32'h0);
    endtask

    task automatic rd(input logic [13:0] a);
        do_cycle(1'b1, a, 1'b0, 14'h0, 8'h0, 32'h0);
    endtask

    task automatic wr(input logic [13:0] a, input logic [7:0] be, input logic [31:0] d);
        do_cycle(1'b0, 14'h0, 1'b1, a, be, d);
    endtask

    task automatic commit(input int ch);
        wr(14'h1000 | 14'(ch << 3) | 14'd1, 8'h01, 32'h0100_0000);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        sys_rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic check_live(input int ch);
        check_val("live_if_v4",    64'(if_v4addr[32*ch +: 32]),    64'(m_lv_if_v4[ch]));
        check_val("live_if_mac",   64'(if_macaddr[48*ch +: 48]),   64'(m_lv_if_mac[ch]));
        check_val("live_dest_v4",  64'(dest_v4addr[32*ch +: 32]),  64'(m_lv_dv4[ch]));
        check_val("live_dest_mac", 64'(dest_macaddr[48*ch +: 48]), 64'(m_lv_dmac[ch]));
    endtask

    sb_t mon_e;
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check_val("rd_unexpected", 64'(rd_data), 64'hDEAD_0000_0000);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("rd_data", 64'(rd_data), 64'(mon_e.data));
                check_val("rd_latency", 64'(cyc), 64'(mon_e.cyc + 1));
            end
        end else begin
            check_val("rd_idle_zero", 64'(rd_data), 64'h0);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 sys_rst = 1'b0;
        check_val("rst_rd_valid", 64'(rd_valid), 64'h0);
        check_val("rst_rd_data",  64'(rd_data),  64'h0);
        check_val("rst_wr_busy",  64'(wr_busy),  64'h0);
        for (int n = 0; n < NUM_CH; n++) check_live(n);

        // Basic read of ch1 if_v4addr
        rd(14'h1008);
        idle(1);
        check_val("ch1_v4_const", 64'(m_sh_if_v4[1]), 64'h0A00_15C8);

        // Shadow write then commit on ch2
        wr(14'h1012, 8'h0F, 32'h1122_3344);
        idle(1);
        check_live(2);
        rd(14'h1011);
        commit(2);
        rd(14'h1015);
        rd(14'h1011);
        check_live(2);
        check_val("ch2_mac_committed", 64'(if_macaddr[2*48 +: 48]), 64'h1122_3344_0003);

        // Partial byte enables, same-cycle read/write, offset-3 lane limit
        wr(14'h1004, 8'h02, 32'h00AB_0000);
        rd(14'h1004);
        do_cycle(1'b1, 14'h1000, 1'b1, 14'h1000, 8'h09, 32'hC0A8_0101);
        rd(14'h1000);
        wr(14'h100B, 8'h0F, 32'hDEAD_BEEF);
        rd(14'h100B);
        wr(14'h103F, 8'h0C, 32'h1234_5678);
        rd(14'h103F);
        rd(14'h103E);
        wr(14'h1001, 8'h0F, 32'h0000_0000);
        rd(14'h1001);
        idle(1);
        check_live(0);

        // Write during busy is dropped
        commit(0);
        wr(14'h1000, 8'h0F, 32'hFFFF_FFFF);
        rd(14'h1000);
        rd(14'h1001);
        idle(1);
        check_live(0);

        // Counter wrap on ch3
        for (int i = 0; i < 255; i++) begin
            commit(3);
            idle(1);
        end
        rd(14'h101D);
        commit(3);
        rd(14'h101D);
        idle(1);

        // BIOS, reserved regions, nonexistent channel
        rd(14'h3004);
        rd(14'h3FFF);
        rd(14'h0008);
        rd(14'h2008);
        wr(14'h1028, 8'h0F, 32'hAAAA_5555);
        rd(14'h1028);
        wr(14'h0000, 8'h0F, 32'h5555_AAAA);
        commit(5);
        rd(14'h1029);
        rd(14'h102D);
        idle(1);
        for (int n = 0; n < NUM_CH; n++) check_live(n);

        // Reset in the cycle after a commit wins
        wr(14'h1008, 8'h0F, 32'h0102_0304);
        commit(1);
        do_reset();
        idle(1);
        for (int n = 0; n < NUM_CH; n++) check_live(n);
        rd(14'h1008);
        rd(14'h100D);
        rd(14'h1009);
        idle(3);

        check_val("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
